// File: rtl/muldiv_seq.sv
// muldiv_seq: multi-cycle unsigned 16-bit multiply / divide sequencer.
//
// This block drives the operands and opcode of the CPU's combinational 16-bit
// ALU. It runs one iteration per clock for 16 clocks, then presents the
// result until it is accepted.
//
// Ports:
//   i_clk     - clock; all logic updates on the rising edge
//   i_rst_n   - synchronous active-low reset
//   i_valid   - request valid
//   o_ready   - request ready; high only in IDLE, and never while in reset
//   i_op      - 0 = MUL (low 16 bits of a*b), 1 = DIVU (a / b, unsigned)
//   i_a       - multiplicand / dividend
//   i_b       - multiplier / divisor
//   o_valid   - result valid; high in DONE
//   i_ready   - result accepted
//   o_r       - product low half / quotient
//   o_r2      - 0 for MUL / remainder for DIVU
//   o_alu_a   - ALU operand A (0 outside RUN)
//   o_alu_b   - ALU operand B (0 outside RUN)
//   o_alu_op  - ALU opcode: 000 zero, 001 add, 010 sub
//   i_alu_r   - ALU result, combinational from o_alu_*
module muldiv_seq (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic        i_op,
    input  logic [15:0] i_a,
    input  logic [15:0] i_b,
    output logic        o_valid,
    input  logic        i_ready,
    output logic [15:0] o_r,
    output logic [15:0] o_r2,
    output logic [15:0] o_alu_a,
    output logic [15:0] o_alu_b,
    output logic [2:0]  o_alu_op,
    input  logic [15:0] i_alu_r
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [2:0] ALU_ZERO = 3'b000;
    localparam logic [2:0] ALU_ADD  = 3'b001;
    localparam logic [2:0] ALU_SUB  = 3'b010;

    state_t      state_reg, state_next;
    logic [3:0]  cnt_reg;
    logic        op_reg;
    logic        dz_reg;
    // acc_reg holds the MUL accumulator or the DIVU partial remainder.
    // mcand_reg holds the MUL multiplicand (shifted left each iteration) or
    // the DIVU divisor (held constant).
    // shift_reg holds the MUL multiplier (shifted right) or the DIVU
    // dividend/quotient (shifted left, quotient bits entering at the LSB).
    logic [15:0] acc_reg;
    logic [15:0] mcand_reg;
    logic [15:0] shift_reg;
    logic [15:0] dividend_reg;
    logic [15:0] r_reg;
    logic [15:0] r2_reg;

    logic        accept;
    logic        last_iter;

    // Iteration datapath
    logic [16:0] shifted;
    logic        ok;
    logic [15:0] mcand_shl;
    logic [15:0] mplier_shr;
    logic [15:0] q_shl;
    logic [15:0] acc_next;
    logic [15:0] mcand_next;
    logic [15:0] shift_next;
    logic [15:0] r_next;
    logic [15:0] r2_next;

    assign accept    = i_valid && o_ready;
    assign last_iter = (state_reg == RUN) && (cnt_reg == 4'd15);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept)    state_next = RUN;
            RUN:     if (last_iter) state_next = DONE;
            DONE:    if (i_ready)   state_next = IDLE;
            default:                state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs. Gating with i_rst_n keeps the handshake and ALU
    // outputs quiet for the whole time reset is held, including the cycle
    // before the first reset edge has been seen.
    // ------------------------------------------------------------------
    always_comb begin
        o_ready  = 1'b0;
        o_valid  = 1'b0;
        o_alu_a  = 16'h0000;
        o_alu_b  = 16'h0000;
        o_alu_op = ALU_ZERO;
        if (i_rst_n) begin
            case (state_reg)
                IDLE: o_ready = 1'b1;
                RUN: begin
                    o_alu_a  = op_reg ? shifted[15:0] : acc_reg;
                    o_alu_b  = mcand_reg;
                    o_alu_op = op_reg ? ALU_SUB : ALU_ADD;
                end
                DONE: o_valid = 1'b1;
                default: ;
            endcase
        end
    end

    assign o_r  = r_reg;
    assign o_r2 = r2_reg;

    // ------------------------------------------------------------------
    // Iteration datapath
    // ------------------------------------------------------------------
    // Restoring divide step: the remainder takes the next dividend bit. A
    // set bit 16 means the shifted value already exceeds any 16-bit
    // divisor, so the subtraction always succeeds.
    assign shifted = {acc_reg, shift_reg[15]};
    assign ok      = shifted[16] | (shifted[15:0] >= mcand_reg);

    // Local shift networks; the ALU is used only for add/sub.
    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_shift
            if (gi == 0) begin : g_lsb
                assign mcand_shl[gi] = 1'b0;
                assign q_shl[gi]     = ok;
            end else begin : g_upper
                assign mcand_shl[gi] = mcand_reg[gi-1];
                assign q_shl[gi]     = shift_reg[gi-1];
            end
            if (gi == 15) begin : g_msb
                assign mplier_shr[gi] = 1'b0;
            end else begin : g_lower
                assign mplier_shr[gi] = shift_reg[gi+1];
            end
        end
    endgenerate

    always_comb begin
        if (op_reg) begin
            acc_next   = ok ? i_alu_r : shifted[15:0];
            mcand_next = mcand_reg;
            shift_next = q_shl;
        end else begin
            acc_next   = shift_reg[0] ? i_alu_r : acc_reg;
            mcand_next = mcand_shl;
            shift_next = mplier_shr;
        end
    end

    // Result as it will stand after the final iteration. A zero divisor
    // still runs all iterations, but the reported result is overridden.
    always_comb begin
        if (op_reg) begin
            r_next  = dz_reg ? 16'hFFFF     : shift_next;
            r2_next = dz_reg ? dividend_reg : acc_next;
        end else begin
            r_next  = acc_next;
            r2_next = 16'h0000;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            cnt_reg      <= 4'd0;
            op_reg       <= 1'b0;
            dz_reg       <= 1'b0;
            acc_reg      <= 16'h0000;
            mcand_reg    <= 16'h0000;
            shift_reg    <= 16'h0000;
            dividend_reg <= 16'h0000;
            r_reg        <= 16'h0000;
            r2_reg       <= 16'h0000;
        end else if (accept) begin
            cnt_reg      <= 4'd0;
            op_reg       <= i_op;
            dz_reg       <= (i_b == 16'h0000);
            acc_reg      <= 16'h0000;
            mcand_reg    <= i_op ? i_b : i_a;
            shift_reg    <= i_op ? i_a : i_b;
            dividend_reg <= i_a;
        end else if (state_reg == RUN) begin
            cnt_reg   <= cnt_reg + 4'd1;
            acc_reg   <= acc_next;
            mcand_reg <= mcand_next;
            shift_reg <= shift_next;
            if (last_iter) begin
                r_reg  <= r_next;
                r2_reg <= r2_next;
            end
        end
    end

endmodule

// File: doc/muldiv_seq.md
# muldiv_seq

Multi-cycle unsigned multiply/divide sequencer that acts as the initiator on the CPU's combinational 16-bit ALU port. It drives ALU operands and opcodes one iteration per clock and captures the ALU result. It takes a 16-bit multiply or unsigned divide request over a valid/ready handshake and returns the result over a second valid/ready handshake. Fixed latency; the ALU itself is unchanged and is instantiated beside this block.

## Interface
- No parameters; datapath fixed at 16 bits, iteration count fixed at 16.
- i_clk  in  1  clock; all logic on rising edge
- i_rst_n  in  1  synchronous active-low reset
- i_valid  in  1  request valid
- o_ready  out  1  request ready; high only in IDLE
- i_op  in  1  0 = MUL (low 16 bits of a*b), 1 = DIVU (a / b unsigned)
- i_a  in  16  multiplicand / dividend
- i_b  in  16  multiplier / divisor
- o_valid  out  1  result valid
- i_ready  in  1  result accepted
- o_r  out  16  product low half / quotient
- o_r2  out  16  0 for MUL / remainder for DIVU
- o_alu_a  out  16  ALU operand A
- o_alu_b  out  16  ALU operand B
- o_alu_op  out  3  ALU opcode: 000 zero, 001 add, 010 sub; no other codes issued
- i_alu_r  in  16  ALU result, combinational from o_alu_*

## Operation
- States: IDLE, RUN, DONE. Transitions:
  - IDLE->RUN on i_valid&&o_ready.
  - RUN->DONE when the 4-bit iteration counter reaches 15.
  - DONE->IDLE on i_ready.
- Accept: latch op and divisor; the dividend/multiplier goes into its shift register.
  - MUL: acc=0, mcand=i_a, mplier=i_b.
  - DIVU: rem=0, q=i_a, dz=(i_b==0).
- MUL iteration:
  - Drive o_alu_a=acc, o_alu_b=mcand, o_alu_op=001.
  - If mplier[0], acc<=i_alu_r.
  - mcand<=mcand<<1 and mplier<=mplier>>1 (logical shift, done locally, not via the ALU).
- DIVU iteration (restoring):
  - shifted={rem,q[15]} (17 bits).
  - Drive o_alu_a=shifted[15:0], o_alu_b=divisor, o_alu_op=010.
  - ok=shifted[16] | (shifted[15:0]>=divisor).
  - rem<=ok ? i_alu_r : shifted[15:0]; q<={q[14:0],ok}.
- Results:
  - MUL: o_r=acc, o_r2=0; wraps modulo 2^16.
  - DIVU: o_r=q, o_r2=rem.
- Divide by zero (dz): still runs 16 iterations. Result is forced to o_r=0xFFFF, o_r2=dividend.
- Outside RUN: o_alu_a=0, o_alu_b=0, o_alu_op=000.
- DONE:
  - o_r/o_r2 are registered and held stable until the handshake.
  - i_valid is ignored (o_ready low).
  - A single op is in flight; there is no queueing.

## Timing
- Reset (i_rst_n low at an edge):
  - State goes to IDLE, counters clear.
  - o_valid=0, o_r=0, o_r2=0, o_alu_*=0, o_ready=0 while in reset.
  - o_ready=1 in the first cycle after release.
- Reset mid-RUN or mid-DONE aborts the op; no result is delivered.
- Acceptance at edge E0. RUN occupies the 16 cycles after E0; iterations are captured at edges E1..E16.
- o_valid is high from the cycle after E16, i.e. 17 cycles after the accept cycle.
- o_valid&&i_ready at edge Ed: o_valid low and o_ready high after Ed. The earliest next accept is at edge Ed+1.
- Minimum spacing between accepts is 18 cycles.
- i_valid in the same cycle as the DONE handshake is not accepted.
- i_a/i_b/i_op are sampled only at the accept edge; later changes have no effect.

## Test plan
- MUL 0x0003*0x0005 -> o_r=0x000F, o_r2=0x0000; o_valid exactly 17 cycles after accept; o_alu_op=001 for 16 cycles, else 000.
- MUL 0x1234*0x0100 -> o_r=0x3400; MUL 0xFFFF*0xFFFF -> o_r=0x0001 (truncation).
- DIVU 100/7 -> o_r=0x000E, o_r2=0x0002; DIVU 0xFFFF/0x8001 -> o_r=0x0001, o_r2=0x7FFE; DIVU 5/9 -> o_r=0, o_r2=5.
- DIVU 0x1234/0 -> o_r=0xFFFF, o_r2=0x1234, same 17-cycle latency.
- Hold i_ready low 5 cycles in DONE while pulsing i_valid:
  - o_valid, o_r and o_r2 stay stable; o_ready=0; no accept.
  - After i_ready=1, o_ready=1 the next cycle and the following request is accepted.
- Assert i_rst_n=0 for one cycle at RUN iteration 8:
  - Next cycle: o_valid=0, o_alu_op=000, o_ready=0 during reset and 1 after release.
  - A subsequent MUL 7*6 returns 0x002A.
